// File: rtl/ld202_pkg.sv
// Shared definitions for the push-button event counter: edge-select codes and
// the width helper for the debounce stable counter.
// Latency: n/a (constants and functions only).  Backpressure: n/a.
package ld202_pkg;

   // Per-channel edge select codes, driven on type_i
   localparam logic [1:0] EDGE_LEVEL = 2'b00;   // event every cycle the level is high
   localparam logic [1:0] EDGE_RISE  = 2'b01;   // event on 0->1
   localparam logic [1:0] EDGE_FALL  = 2'b10;   // event on 1->0
   localparam logic [1:0] EDGE_BOTH  = 2'b11;   // event on either change

   // Width of a counter able to hold 0..cycles, never narrower than one bit
   function automatic int unsigned dbc_width(input int unsigned cycles);
      int unsigned w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, stable-run debouncer, registered edge detect.
// Latency: raw change -> level_o after DEBOUNCE_CYCLES+2 edges, event_o one edge later.
// Backpressure: none; free-running, an event strobe is never held off.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   key_i       : raw asynchronous key level
//   type_i      : edge select (EDGE_LEVEL / EDGE_RISE / EDGE_FALL / EDGE_BOTH)
//   level_o     : debounced level
//   event_o     : registered event strobe
module key_debounce
   import ld202_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter bit          IDLE_LEVEL      = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_i,
   input  logic [1:0] type_i,
   output logic       level_o,
   output logic       event_o
);

   localparam int unsigned    CW   = dbc_width(DEBOUNCE_CYCLES);
   // Run length already seen when the accepting mismatch arrives
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] stable_q, stable_d;
   logic          level_q, level_d;
   logic          level_dly_q, level_dly_d;
   logic          event_q, event_d;

   always_comb begin
      sync1_d     = key_i;
      sync2_d     = sync1_q;
      stable_d    = '0;
      level_d     = level_q;
      level_dly_d = level_q;
      event_d     = 1'b0;

      // Any sample that agrees with the current level restarts the run
      if (sync2_q != level_q) begin
         if (stable_q == LAST) begin
            level_d = sync2_q;
         end else begin
            stable_d = stable_q + 1'b1;
         end
      end

      // Only the level history decides events, so retyping a channel is glitch-free
      case (type_i)
         EDGE_LEVEL: event_d = level_q;
         EDGE_RISE:  event_d = level_q & ~level_dly_q;
         EDGE_FALL:  event_d = ~level_q & level_dly_q;
         EDGE_BOTH:  event_d = level_q ^ level_dly_q;
         default:    event_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= IDLE_LEVEL;
         sync2_q     <= IDLE_LEVEL;
         stable_q    <= '0;
         level_q     <= IDLE_LEVEL;
         // Delayed copy matches the level so reset never looks like an edge
         level_dly_q <= IDLE_LEVEL;
         event_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         stable_q    <= stable_d;
         level_q     <= level_d;
         level_dly_q <= level_dly_d;
         event_q     <= event_d;
      end
   end

   assign level_o = level_q;
   assign event_o = event_q;

endmodule

// File: rtl/key_event_counter.sv
// Multi-channel debounced key event counter with wrap/saturate and sticky overflow.
// Latency: raw key change -> count_o update in DEBOUNCE_CYCLES+4 edges; clr_i in 1 edge.
// Backpressure: none; every enabled event is counted, clr_i wins over a coincident event.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   key_i      : raw key levels, one per channel
//   type_i     : 2-bit edge select per channel, channel 0 in bits [1:0]
//   en_i       : per-channel count enable
//   clr_i      : per-channel clear of count and overflow
//   level_o    : debounced levels
//   event_o    : one-cycle event strobes (held high in level mode)
//   count_o    : packed counters, channel 0 in the LSBs
//   ovf_o      : sticky overflow flags
module key_event_counter
   import ld202_pkg::*;
#(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned CNT_WIDTH       = 18,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter bit          IDLE_LEVEL      = 1'b1,
   parameter bit          SATURATE        = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CHANNELS-1:0]           key_i,
   input  logic [2*CHANNELS-1:0]         type_i,
   input  logic [CHANNELS-1:0]           en_i,
   input  logic [CHANNELS-1:0]           clr_i,
   output logic [CHANNELS-1:0]           level_o,
   output logic [CHANNELS-1:0]           event_o,
   output logic [CNT_WIDTH*CHANNELS-1:0] count_o,
   output logic [CHANNELS-1:0]           ovf_o
);

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic                 ev;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                 ovf_q, ovf_d;

      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_deb (
         .clk     (clk),
         .rst_n   (rst_n),
         .key_i   (key_i[ch]),
         .type_i  (type_i[2*ch +: 2]),
         .level_o (level_o[ch]),
         .event_o (ev)
      );

      always_comb begin
         cnt_d = cnt_q;
         ovf_d = ovf_q;
         if (clr_i[ch]) begin
            cnt_d = '0;
            ovf_d = 1'b0;
         end else if (ev && en_i[ch]) begin
            if (cnt_q == {CNT_WIDTH{1'b1}}) begin
               ovf_d = 1'b1;
               cnt_d = SATURATE ? cnt_q : '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
         end
      end

      assign event_o[ch]                         = ev;
      assign count_o[ch*CNT_WIDTH +: CNT_WIDTH]  = cnt_q;
      assign ovf_o[ch]                           = ovf_q;
   end

endmodule

// File: doc/key_event_counter.md
# key_event_counter

Parametrised multi-channel push-button event counter for the DE2i-150 board top level. Each channel synchronises a raw key input, debounces it, and detects a selectable edge type. It counts the detected events in a per-channel counter with wrap or saturate mode, per-channel clear and sticky overflow. It sits between the board KEY/SW pins and the LEDR/HEX display logic, and replaces ad-hoc edge-detect-plus-counter glue in the top level.

## Interface
- CHANNELS, 4, number of independent key channels (1..8)
- CNT_WIDTH, 18, width of each event counter
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a level change (20 ms at 50 MHz); must be ≥1
- IDLE_LEVEL, 1, debounced level after reset (board keys are active-low, idle high)
- SATURATE, 0, 0 = counter wraps at max, 1 = counter holds at max
- clk  input  1  system clock (CLOCK_50)
- rst_n  input  1  synchronous active-low reset
- key_i  input  CHANNELS  raw asynchronous key levels
- type_i  input  2*CHANNELS  per-channel edge select: 00 level-high, 01 rising, 10 falling, 11 both
- en_i  input  CHANNELS  per-channel count enable
- clr_i  input  CHANNELS  per-channel synchronous counter/overflow clear
- level_o  output  CHANNELS  debounced key level
- event_o  output  CHANNELS  one-cycle event strobe
- count_o  output  CNT_WIDTH*CHANNELS  packed counters, channel 0 in LSBs
- ovf_o  output  CHANNELS  sticky overflow flag

## Operation
- Reset (rst_n low at a clk edge): sync flops and level_o are set to IDLE_LEVEL. The stable counter, event_o, count_o and ovf_o are set to 0. Reset mid-debounce abandons the pending change.
- Synchroniser: two flops per channel. sync is key_i delayed by 2 cycles.
- Debounce: stable counter increments each cycle sync ≠ level_o. It returns to 0 whenever sync = level_o. When sync ≠ level_o on the DEBOUNCE_CYCLES-th consecutive cycle, level_o takes the sync value and the counter clears.
- Edge detect (registered, driven from level_o and its 1-cycle delayed copy):
  - 01: event on a 0→1 change of level_o.
  - 10: event on a 1→0 change.
  - 11: event on either change.
  - 00: event_o high every cycle that level_o is 1 (level mode).
- type_i is sampled every cycle. Changing it never creates a spurious edge, because only the level history matters.
- Counter, per channel, in priority order:
  - clr_i clears count to 0 and ovf to 0, and discards a coincident event.
  - Otherwise, event_o & en_i increments the count.
  - At 2^CNT_WIDTH−1 with an increment: SATURATE=0 wraps to 0, SATURATE=1 holds the value. Either way ovf_o is set and stays set until clr_i or reset.
- Channels are fully independent. Simultaneous events on all channels each increment their own counter.

## Timing
- Raw change sampled at edge k: sync changes at k+2, level_o at k+1+DEBOUNCE_CYCLES+1, event_o at the following edge (1 cycle high), count_o updated at the edge after that.
- Total key-to-count latency: DEBOUNCE_CYCLES+4 edges.
- A bounce shorter than DEBOUNCE_CYCLES sync samples produces no level_o change and no event.
- Back-to-back accepted changes are separated by at least DEBOUNCE_CYCLES cycles. event_o is never high for more than 1 cycle in edge modes.
- clr_i takes effect at the next edge: count_o = 0 and ovf_o = 0 one cycle after clr_i is sampled.

## Structure
- Shared include/package `ld202_pkg`: edge-type constants EDGE_LEVEL=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11, and a clog2 function for the debounce counter width ($clog2(DEBOUNCE_CYCLES+1)).
- Sub-module `key_debounce`: one channel's synchroniser, stable counter, level register and edge detect. Outputs level and event.
- Top of block: generate loop over CHANNELS instantiating key_debounce plus the per-channel counter/overflow logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_WIDTH=4, CHANNELS=2.
- Reset: hold rst_n low 3 cycles with key_i=2'b00 → level_o=2'b11, count_o=0, ovf_o=0, event_o=0.
- Clean press on ch0, type 10, en=1: key_i[0] 1→0 and held → event_o[0] high exactly 1 cycle, 7 edges after sampling; count ch0=1 at 8 edges.
- Bounce rejection: key_i[0] toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 → no event, level_o[0] stays 1, count unchanged.
- Both-edge and wrap: ch1 type 11, SATURATE=0, 16 full press/release pairs → 32 events, count wraps past 15 twice, ends at 0, ovf_o[1]=1. With SATURATE=1, count holds at 15 and ovf_o[1]=1.
- Clear priority: assert clr_i[0] in the same cycle as event_o[0] → count ch0=0, ovf_o[0]=0; the next event gives count 1.
- Enable and level mode: ch0 type 00, level high for 5 cycles, en_i[0]=0 for the first 2 of them → count increases by 3; ch1 unaffected.
